dot_product_sequencer: RTL and testbench

Controller that runs a batch of 4-lane dot products between operand memory A and operand memory B and writes results into the result memory. It replaces software-driven per-entry sequencing: one `start` pulse processes `vec_count` consecutive entries with one new entry issued per cycle. It sits between the two operand RAMs (synchronous read, 1-cycle latency) and the result RAM (synchronous write), inside the dot-product top level.

---
 rtl/dot_product_sequencer.sv | 134 +++++++++++++
 tb/tb_dot_product_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// Batch sequencer for 4-lane dot products: reads A/B operand words,
// multiplies lane-wise, sums, and writes results at one entry per cycle.
module dot_product_sequencer #(
  parameter int DATA_WIDTH           = 32,
  parameter int VECTOR_WIDTH         = 4,
  parameter int VECTOR_ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH           = 5,
  parameter int RESULT_WIDTH         = 2*VECTOR_ELEMENT_WIDTH+2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   vec_count,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int EW       = VECTOR_ELEMENT_WIDTH;
  localparam int PW       = 2*EW;
  localparam int MEM_SIZE = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH:0]   count_q, idx_q, count_sat;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, widx_q;
  logic                  v1, v2, v3;
  logic                  accept, last_issue;
  logic [PW-1:0]         prod_q [VECTOR_WIDTH];
  logic [RESULT_WIDTH-1:0] sum_q, sum_d;

  assign count_sat  = (vec_count > MAX_CNT) ? MAX_CNT : vec_count;
  assign accept     = (state == IDLE) && start;
  assign last_issue = (idx_q == count_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (count_sat == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        // leave once the final entry is in its write cycle
        if (v3 && !v2 && !v1) state_nx = FINISH;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      widx_q  <= '0;
    end else begin
      if (accept) begin
        src_q   <= src_base;
        dst_q   <= dst_base;
        count_q <= count_sat;
        idx_q   <= '0;
        widx_q  <= '0;
      end else begin
        if (state == ISSUE) idx_q <= idx_q + 1'b1;
        if (v3) widx_q <= widx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= rd_en;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < VECTOR_WIDTH; k++)
        prod_q[k] <= '0;
    end else if (v1) begin
      for (int k = 0; k < VECTOR_WIDTH; k++)
        prod_q[k] <= PW'(rd_data_a[k*EW +: EW])
                   * PW'(rd_data_b[k*EW +: EW]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < VECTOR_WIDTH; k++)
      sum_d = sum_d + RESULT_WIDTH'(prod_q[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     sum_q <= '0;
    else if (v2) sum_q <= sum_d;
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);
  assign rd_en   = (state == ISSUE);
  assign rd_addr = src_q + idx_q[ADDR_WIDTH-1:0];
  assign wr_en   = v3;
  assign wr_addr = dst_q + widx_q;
  assign wr_data = DATA_WIDTH'(sum_q);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: memory models plus a cycle-indexed
// reference of the batch timing and dot-product results.
module tb_dot_product_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  vec_count;
  logic [4:0]  src_base, dst_base;
  logic        busy, done, rd_en, wr_en;
  logic [4:0]  rd_addr, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] res_mem [32];
  logic [31:0] last_wr;

  int tests = 0;
  int fails = 0;

  dot_product_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_count (vec_count),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
    if (wr_en) res_mem[wr_addr] <= wr_data;
  end

  function automatic int dot(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int k = 0; k < 4; k++)
      s += int'(a[k*8 +: 8]) * int'(b[k*8 +: 8]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
  endtask

  // Caller is positioned just after a falling edge; start is sampled
  // on the next rising edge (cycle 0).
  task automatic run_batch(input int cnt, input int src, input int dst,
                           input bit junk, input int abort_at);
    int n, last, i;
    bit exp_rd, exp_wr;
    n    = (cnt > 32) ? 32 : cnt;
    last = (n == 0) ? 1 : n + 4;
    start     = 1'b1;
    vec_count = cnt[5:0];
    src_base  = src[4:0];
    dst_base  = dst[4:0];
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      exp_rd = (c >= 1) && (c <= n);
      exp_wr = (c >= 4) && (c <= n + 3);
      check("busy", 32'(busy), 32'(c <= last));
      check("done", 32'(done), 32'(c == last));
      check("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd)
        check("rd_addr", 32'(rd_addr), 32'((src + c - 1) % 32));
      check("wr_en", 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
        i = c - 4;
        check("wr_addr", 32'(wr_addr), 32'((dst + i) % 32));
        last_wr = 32'(dot(mem_a[(src + i) % 32], mem_b[(src + i) % 32]));
      end
      check("wr_data", wr_data, last_wr);
      start = junk && (c == 2 || c == n + 2);
      if (start) begin
        vec_count = 6'($urandom_range(1, 40));
        src_base  = 5'($urandom);
        dst_base  = 5'($urandom);
      end
      if (abort_at == c) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        last_wr = '0;
        repeat (3) begin
          @(negedge clk);
          check("rst_rd_en", 32'(rd_en), 32'd0);
          check("rst_wr_en", 32'(wr_en), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) begin
      mem_a[k] = $urandom;
      mem_b[k] = $urandom;
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    vec_count = '0;
    src_base  = '0;
    dst_base  = '0;
    last_wr   = '0;
    for (int k = 0; k < 32; k++) begin
      mem_a[k]   = '0;
      mem_b[k]   = '0;
      res_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      mem_a[k] = {8'(4 + k), 8'(3 + k), 8'(2 + k), 8'(1 + k)};
      mem_b[k] = mem_a[k];
    end
    run_batch(12, 0, 0, 1'b0, 0);
    check("base_r0", res_mem[0], 32'd30);
    check("base_r11", res_mem[11], 32'd734);

    mem_a[5] = 32'hFFFF_FFFF;
    mem_b[5] = 32'hFFFF_FFFF;
    run_batch(1, 5, 9, 1'b0, 0);
    check("width_r9", res_mem[9], 32'h0003_F804);

    fill_random();
    run_batch(4, 30, 31, 1'b0, 0);
    check("wrap_r2", res_mem[2], 32'(dot(mem_a[1], mem_b[1])));

    run_batch(0, 7, 7, 1'b0, 0);
    run_batch(40, 3, 17, 1'b0, 0);

    run_batch(5, 10, 20, 1'b1, 0);
    run_batch(3, 1, 2, 1'b0, 0);

    run_batch(12, 0, 0, 1'b0, 6);
    run_batch(2, 14, 25, 1'b0, 0);
    check("post_rst_r26", res_mem[26], 32'(dot(mem_a[15], mem_b[15])));

    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_batch(int'($urandom_range(1, 32)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), 1'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
